seg_mux_capture: RTL and testbench
==================================

SEG_MUX_CAPTURE -- requirements
Module: seg_mux_capture

Interface
REQ-001 Parameter SETTLE, default 4, is the number of consecutive stable synchronized cycles (range 2..255) required before a digit is captured.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a,b,c,d,e,f,g  input  1 each  multiplexed segment lines, active-low (0 = segment lit).
REQ-005 D  input  1  decimal-point line, active-low.
REQ-006 n3,n2,n1,n0  input  1 each  digit anodes, active-low; nK low selects digit K.
REQ-007 ack  input  1  consumer acknowledge of the current frame.
REQ-008 digits  output  16  captured hex values; [15:12]=digit3 ... [3:0]=digit0.
REQ-009 dp_out  output  4  captured decimal points, 1 = lit; bit K = digit K.
REQ-010 bad  output  4  bit K = digit K held a segment pattern not in the hex table.
REQ-011 valid  output  1  a complete frame is held on digits/dp_out/bad.
REQ-012 overrun  output  1  sticky; a complete frame was dropped while valid was high.
REQ-013 oh_err  output  1  sticky; more than one anode was low on some synchronized cycle.

Function
REQ-014 All 12 display inputs SHALL pass through a 2-flop synchronizer before use.
REQ-015 The dwell index SHALL be K when exactly one synchronized anode is low; with no anode low the block SHALL be idle and capture nothing.
REQ-016 With two or more anodes low, the block SHALL be idle, capture nothing, and set oh_err.
REQ-017 A stable counter SHALL reset to 0 when the index, idle status, segments or D differ from the previous synchronized cycle; otherwise it SHALL increment, saturating at SETTLE.
REQ-018 A digit SHALL be captured on the first cycle the counter reaches SETTLE, and only once per dwell.
REQ-019 Decode table (lit segments), hex values 0..F: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-020 An unmatched pattern SHALL capture nibble 0 and set the pending bad bit for that digit.
REQ-021 A 4-bit capture mask SHALL track digits captured in the current frame; recapturing a digit before frame completion SHALL overwrite its pending value.
REQ-022 When the mask becomes 1111, the frame is complete and the mask SHALL clear on the same cycle.
REQ-023 If valid=0, or valid=1 and ack=1, on the completion cycle, the pending frame SHALL load into digits/dp_out/bad and valid SHALL be 1 next cycle.
REQ-024 If valid=1 and ack=0 on the completion cycle, the outputs SHALL hold, the frame SHALL be dropped, and overrun SHALL be set.
REQ-025 valid=1 with ack=1 and no completion SHALL clear valid next cycle; ack while valid=0 SHALL have no effect.
REQ-026 overrun and oh_err SHALL clear only on an accepted ack (valid=1, ack=1) or on reset.
REQ-027 Latency from a stable input change to capture SHALL be 2+SETTLE cycles; completion to valid SHALL be 1 cycle.

Reset
REQ-028 When rst=1 at a clock edge, digits=0, dp_out=0, bad=0, valid=0, overrun=0, oh_err=0; the mask, stable counter, synchronizers and pending registers SHALL also clear.
REQ-029 Reset SHALL take priority over all other activity; a partially captured frame SHALL be discarded.

Configuration
REQ-030 With DP_CAPTURE_EN defined, D SHALL be synchronized, included in the stability check, and captured inverted into dp_out.
REQ-031 Without DP_CAPTURE_EN, D SHALL be ignored, excluded from the stability check, and dp_out SHALL be constant 0.

Verification
REQ-032 Drive digits 3,2,1,0 as patterns for 1,2,3,4, each for 8 cycles with SETTLE=4 and ack=0 -> digits=16'h1234, bad=0, valid=1 one cycle after digit 0 captures.
REQ-033 Leave valid=1 with ack=0 and drive a second full frame -> outputs keep 16'h1234 and overrun=1; then pulse ack -> valid=0, overrun=0.
REQ-034 Hold digit 2 for only 3 stable cycles, then give it a full dwell -> it is captured only on the full dwell, and the frame completes with the correct value.
REQ-035 Drive segments lit = abg on digit 1 -> nibble 1 = 0 and bad=4'b0010 in the completed frame.
REQ-036 Pull n3 and n0 low together for 10 cycles -> no capture and oh_err=1; assert rst mid-frame -> all outputs 0 and the mask is cleared.
REQ-037 With DP_CAPTURE_EN defined, hold D low during digit 2 -> dp_out=4'b0100; without it, dp_out=0.

Source files
------------

// File: rtl/seg_mux_capture.sv
// seg_mux_capture: recovers the four hex digits shown on a multiplexed,
// active-low 7-segment display and presents them as complete frames.
// Optional feature macro: DP_CAPTURE_EN (capture decimal points into dp_out).
module seg_mux_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        D,
    input  logic        n3,
    input  logic        n2,
    input  logic        n1,
    input  logic        n0,
    input  logic        ack,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  bad,
    output logic        valid,
    output logic        overrun,
    output logic        oh_err
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned CNT_W = 8;

    // Synchronizers hold lit/selected (active-high) form so a cleared
    // synchronizer reads as a blank display rather than all anodes low.
    logic [SEG_W-1:0] seg_s1, seg_s2, seg_s3;
    logic [AN_W-1:0]  an_s1, an_s2;
    logic             dp_s2, dp_s3;

    logic [1:0]       idx, prev_idx;
    logic             idle, prev_idle, multi;
    logic [CNT_W-1:0] cnt;
    logic             changed_c, capture_c;

    logic [3:0]       dec_nib;
    logic             dec_bad;

    logic [3:0]       mask, mask_nx;
    logic [15:0]      pnib, pnib_nx;
    logic [3:0]       pbad, pbad_nx;
    logic             complete_c, load_c, drop_c, acc_c;

    // Two-flop synchronizer for segment and anode lines
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= ~{a, b, c, d, e, f, g};
            seg_s2 <= seg_s1;
            an_s1  <= ~{n3, n2, n1, n0};
            an_s2  <= an_s1;
        end
    end

    // Anode decode: single selected anode gives the dwell index, else idle
    always_comb begin
        idle  = 1'b1;
        idx   = 2'd0;
        multi = 1'b0;
        case (an_s2)
            4'b0000: ;
            4'b0001: begin idle = 1'b0; idx = 2'd0; end
            4'b0010: begin idle = 1'b0; idx = 2'd1; end
            4'b0100: begin idle = 1'b0; idx = 2'd2; end
            4'b1000: begin idle = 1'b0; idx = 2'd3; end
            default: multi = 1'b1;
        endcase
    end

    // Segment pattern to hex nibble; unknown patterns flag bad
    always_comb begin
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (seg_s2)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            default: dec_bad = 1'b1;
        endcase
    end

    assign changed_c = (idle != prev_idle) || (idx != prev_idx) ||
                       (seg_s2 != seg_s3) || (dp_s2 != dp_s3);
    // Fires once per dwell: only on the step from SETTLE-1 to SETTLE
    assign capture_c = !changed_c && !idle && (cnt == CNT_W'(SETTLE - 1));

    // Previous synchronized view and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_idle <= 1'b1;
            prev_idx  <= 2'd0;
            seg_s3    <= '0;
            cnt       <= '0;
        end else begin
            prev_idle <= idle;
            prev_idx  <= idx;
            seg_s3    <= seg_s2;
            if (changed_c) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(SETTLE)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pending frame with the current capture merged in
    always_comb begin
        mask_nx = mask;
        pnib_nx = pnib;
        pbad_nx = pbad;
        if (capture_c) begin
            mask_nx[idx]              = 1'b1;
            pnib_nx[{idx, 2'b00} +: 4] = dec_nib;
            pbad_nx[idx]              = dec_bad;
        end
    end

    assign complete_c = capture_c && (mask_nx == 4'hF);
    assign acc_c      = valid && ack;
    assign load_c     = complete_c && (!valid || ack);
    assign drop_c     = complete_c && valid && !ack;

    // Frame assembly, output hand-off and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            pnib    <= '0;
            pbad    <= '0;
            digits  <= '0;
            bad     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            oh_err  <= 1'b0;
        end else begin
            mask <= complete_c ? 4'h0 : mask_nx;
            pnib <= pnib_nx;
            pbad <= pbad_nx;
            if (load_c) begin
                digits <= pnib_nx;
                bad    <= pbad_nx;
            end
            if (load_c) begin
                valid <= 1'b1;
            end else if (acc_c) begin
                valid <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (acc_c) begin
                overrun <= 1'b0;
            end
            if (multi) begin
                oh_err <= 1'b1;
            end else if (acc_c) begin
                oh_err <= 1'b0;
            end
        end
    end

`ifdef DP_CAPTURE_EN
    logic       dp_s1;
    logic [3:0] pdp, pdp_nx;

    // Pending decimal points with the current capture merged in
    always_comb begin
        pdp_nx = pdp;
        if (capture_c) begin
            pdp_nx[idx] = dp_s2;
        end
    end

    // Decimal-point synchronizer, history, pending and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_s1  <= 1'b0;
            dp_s2  <= 1'b0;
            dp_s3  <= 1'b0;
            pdp    <= '0;
            dp_out <= '0;
        end else begin
            dp_s1 <= ~D;
            dp_s2 <= dp_s1;
            dp_s3 <= dp_s2;
            pdp   <= pdp_nx;
            if (load_c) begin
                dp_out <= pdp_nx;
            end
        end
    end
`else
    logic unused_d;

    assign dp_s2    = 1'b0;
    assign dp_s3    = 1'b0;
    assign dp_out   = 4'h0;
    assign unused_d = D;
`endif

endmodule

// File: tb/tb_seg_mux_capture.sv
// Randomized and directed bench for seg_mux_capture against a
// sample-history reference model built from the decode table strings.
module tb_seg_mux_capture;

    localparam int unsigned SETTLE = 4;
    localparam int          HMAX   = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_lit;   // bit0 = a ... bit6 = g, 1 = lit
    logic [3:0]  an_sel;    // 1 = anode selected
    logic        dp_lit;
    logic        ack;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  bad;
    logic        valid;
    logic        overrun;
    logic        oh_err;

    seg_mux_capture #(.SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (~seg_lit[0]),
        .b       (~seg_lit[1]),
        .c       (~seg_lit[2]),
        .d       (~seg_lit[3]),
        .e       (~seg_lit[4]),
        .f       (~seg_lit[5]),
        .g       (~seg_lit[6]),
        .D       (~dp_lit),
        .n3      (~an_sel[3]),
        .n2      (~an_sel[2]),
        .n1      (~an_sel[1]),
        .n0      (~an_sel[0]),
        .ack     (ack),
        .digits  (digits),
        .dp_out  (dp_out),
        .bad     (bad),
        .valid   (valid),
        .overrun (overrun),
        .oh_err  (oh_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0] sel;    // 0..3 dwell index, 4 = idle
        logic [6:0] seg;
        logic       dp;
    } key_t;

    localparam key_t BLANK = '{sel: 3'd4, seg: 7'd0, dp: 1'b0};

    string tbl_str[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    logic [6:0] tbl_bits[16];

    key_t hist[HMAX];
    bit   mhist[HMAX];
    int   cyc     = 0;
    int   rst_cyc = -1;

    logic [3:0] m_nib[4];
    logic [3:0] m_pbad, m_pdp, m_mask;
    logic [15:0] m_digits;
    logic [3:0] m_dp, m_bad;
    logic m_valid, m_ovr, m_oh;

    function automatic logic [6:0] pat(input string s);
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic key_t key_at(input int j);
        if (j < 0 || j <= rst_cyc) return BLANK;
        return hist[j];
    endfunction

    function automatic bit multi_at(input int j);
        if (j < 0 || j <= rst_cyc) return 1'b0;
        return mhist[j];
    endfunction

    function automatic key_t cur_key();
        key_t k = BLANK;
        if ($countones(an_sel) == 1) begin
            for (int i = 0; i < 4; i++) if (an_sel[i]) k.sel = 3'(i);
        end
        k.seg = seg_lit;
`ifdef DP_CAPTURE_EN
        k.dp = dp_lit;
`else
        k.dp = 1'b0;
`endif
        return k;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        m_pbad = '0; m_pdp = '0; m_mask = '0;
        m_digits = '0; m_dp = '0; m_bad = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_oh = 1'b0;
    endtask

    // One clock edge: a digit is taken once its sample has been identical for
    // exactly SETTLE+1 samples, seen two cycles after the last such sample.
    task automatic model_edge();
        int   e, j, k;
        key_t kj;
        bit   run_ok, acc, complete, load;
        logic [3:0] nib;
        logic       is_bad;
        e = cyc;
        cyc++;
        if (rst) begin
            rst_cyc = e;
            model_clear();
            return;
        end
        hist[e]  = cur_key();
        mhist[e] = ($countones(an_sel) >= 2);
        acc      = m_valid && ack;
        complete = 1'b0;
        load     = 1'b0;
        j  = e - 2;
        kj = key_at(j);
        if (kj.sel != 3'd4) begin
            run_ok = 1'b1;
            for (int i = 1; i <= int'(SETTLE); i++)
                if (key_at(j - i) != kj) run_ok = 1'b0;
            if (key_at(j - int'(SETTLE) - 1) == kj) run_ok = 1'b0;
            if (run_ok) begin
                k = int'(kj.sel);
                nib = 4'h0;
                is_bad = 1'b1;
                for (int v = 0; v < 16; v++)
                    if (tbl_bits[v] == kj.seg) begin nib = 4'(v); is_bad = 1'b0; end
                m_nib[k]  = nib;
                m_pbad[k] = is_bad;
                m_pdp[k]  = kj.dp;
                m_mask[k] = 1'b1;
                if (m_mask == 4'hF) begin
                    complete = 1'b1;
                    m_mask   = '0;
                end
            end
        end
        if (complete && (!m_valid || ack)) begin
            load     = 1'b1;
            m_digits = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_bad    = m_pbad;
            m_dp     = m_pdp;
        end
        if (load) m_valid = 1'b1;
        else if (acc) m_valid = 1'b0;
        if (complete && !load) m_ovr = 1'b1;
        else if (acc) m_ovr = 1'b0;
        if (multi_at(j)) m_oh = 1'b1;
        else if (acc) m_oh = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("outs", 32'({digits, dp_out, bad, valid, overrun, oh_err}),
              32'({m_digits, m_dp, m_bad, m_valid, m_ovr, m_oh}));
    endtask

    task automatic dwell(input int k, input logic [6:0] s, input logic dpl, input int n);
        an_sel  = 4'(1 << k);
        seg_lit = s;
        dp_lit  = dpl;
        repeat (n) step();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int v = 0; v < 16; v++) tbl_bits[v] = pat(tbl_str[v]);
        model_clear();
        rst = 1'b1; ack = 1'b0; seg_lit = '0; an_sel = '0; dp_lit = 1'b0;
        step();
        step();
        check("rst_state", 32'({digits, dp_out, bad, valid, overrun, oh_err}), 32'h0);
        rst = 1'b0;

        // Basic frame 1234
        dwell(3, tbl_bits[1], 1'b0, 8);
        dwell(2, tbl_bits[2], 1'b0, 8);
        dwell(1, tbl_bits[3], 1'b0, 8);
        dwell(0, tbl_bits[4], 1'b0, 8);
        check("f1_digits", 32'(digits), 32'h1234);
        check("f1_bad", 32'(bad), 32'h0);
        check("f1_valid", 32'(valid), 32'h1);

        // Unacknowledged second frame is dropped
        dwell(3, tbl_bits[5], 1'b0, 8);
        dwell(2, tbl_bits[6], 1'b0, 8);
        dwell(1, tbl_bits[7], 1'b0, 8);
        dwell(0, tbl_bits[8], 1'b0, 8);
        check("ovr_digits", 32'(digits), 32'h1234);
        check("ovr_set", 32'(overrun), 32'h1);
        pulse_ack();
        check("ack_valid", 32'(valid), 32'h0);
        check("ack_ovr", 32'(overrun), 32'h0);

        // Short dwell on digit 2 is not captured
        dwell(3, tbl_bits[9], 1'b0, 8);
        dwell(2, tbl_bits[10], 1'b0, 3);
        dwell(1, tbl_bits[11], 1'b0, 8);
        dwell(0, tbl_bits[12], 1'b0, 8);
        check("short_novalid", 32'(valid), 32'h0);
        dwell(2, tbl_bits[10], 1'b0, 8);
        check("short_valid", 32'(valid), 32'h1);
        check("short_digits", 32'(digits), 32'h9ABC);
        pulse_ack();

        // Unknown pattern abg on digit 1
        dwell(3, tbl_bits[0], 1'b0, 8);
        dwell(2, tbl_bits[1], 1'b0, 8);
        dwell(1, pat("abg"), 1'b0, 8);
        dwell(0, tbl_bits[15], 1'b0, 8);
        check("bad_digits", 32'(digits), 32'h010F);
        check("bad_bits", 32'(bad), 32'h2);
        check("bad_valid", 32'(valid), 32'h1);
        pulse_ack();

        // Two anodes low, then reset mid-frame
        an_sel = 4'b1001; seg_lit = tbl_bits[8];
        repeat (10) step();
        check("oh_set", 32'(oh_err), 32'h1);
        check("oh_novalid", 32'(valid), 32'h0);
        dwell(3, tbl_bits[1], 1'b0, 8);
        dwell(2, tbl_bits[2], 1'b0, 8);
        do_reset();
        check("midrst_outs", 32'({digits, dp_out, bad, valid, overrun, oh_err}), 32'h0);
        dwell(1, tbl_bits[3], 1'b0, 8);
        dwell(0, tbl_bits[4], 1'b0, 8);
        check("midrst_mask", 32'(valid), 32'h0);

        // Decimal point on digit 2
        do_reset();
        dwell(3, tbl_bits[5], 1'b0, 8);
        dwell(2, tbl_bits[6], 1'b1, 8);
        dwell(1, tbl_bits[7], 1'b0, 8);
        dwell(0, tbl_bits[8], 1'b0, 8);
        check("dp_digits", 32'(digits), 32'h5678);
`ifdef DP_CAPTURE_EN
        check("dp_out", 32'(dp_out), 32'h4);
`else
        check("dp_out", 32'(dp_out), 32'h0);
`endif
        pulse_ack();

        // Randomized dwells, anodes, patterns, acks and resets
        while (cyc < 3000) begin
            int kind, len;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 10));
            if (kind == 0) an_sel = 4'b0000;
            else if (kind == 1) begin
                an_sel = 4'($urandom);
                if ($countones(an_sel) < 2) an_sel = 4'b0110;
            end else an_sel = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) seg_lit = 7'($urandom);
            else seg_lit = tbl_bits[$urandom_range(0, 15)];
            dp_lit = 1'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < len; i++) begin
                ack = ($urandom_range(0, 5) == 0);
                step();
                rst = 1'b0;
            end
        end
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
